uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Byte-oriented UART receiver for the AHBLITE_SYS SoC: samples the `rx` pin with 16x oversampling, assembles 8N1 frames LSB-first and queues received bytes in a small FIFO drained by a valid/ready handshake. It is the receive-side counterpart of the SoC's `tx` path. The AHB UART peripheral reads it as its RX data/status source, and the system bench uses it as a loopback monitor on `tx`.

## Interface
- `CLK_DIV`, 27: system clocks per oversample tick (50 MHz / (115200·16) ≈ 27); must be ≥ 2.
- `FIFO_DEPTH`, 4: RX FIFO entries; power of two, ≥ 2.

- `CLK`  in  1  system clock.
- `RESETn`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  serial input; asynchronous to `CLK`, idles high.
- `rdata`  out  8  FIFO head byte; valid only while `rvalid`=1.
- `rvalid`  out  1  FIFO non-empty.
- `rready`  in  1  consumer accepts the head byte when `rvalid & rready`.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `ferr`  out  1  one-cycle pulse: stop bit sampled low.
- `perr`  out  1  one-cycle pulse: parity mismatch (tied 0 without `UART_RX_PARITY_EN`).
- `overrun`  out  1  sticky: a good byte arrived while the FIFO was full.
- `clr_ovr`  in  1  synchronous clear of `overrun`.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx_s`.
- A tick counter counts 0..CLK_DIV-1 and emits `tick` on wrap. It runs freely except that it is zeroed when `IDLE` detects a start edge.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY` (macro only), `STOP`. A 4-bit `os_cnt` counts ticks within a bit; a 3-bit `bit_idx` counts data bits.
- **IDLE**: waits for a falling edge of `rx_s`, i.e. previous sample 1 and current sample 0.
  - An `rx` held low from reset never starts a frame; it must first be seen high.
  - On the edge: go to START with `os_cnt`=0.
- **START**: at `os_cnt`=7 (mid-bit):
  - `rx_s`=1: false start; return to IDLE with no error.
  - `rx_s`=0: go to DATA with `os_cnt`=0 and `bit_idx`=0.
- **DATA**: at each `os_cnt`=15, shift `rx_s` into the shift register MSB and shift right, so bit 0 arrives first. After `bit_idx`=7, go to PARITY or STOP.
- **PARITY**: sample at `os_cnt`=15 and compare with the even parity of the data byte.
- **STOP**: sample at `os_cnt`=15, then return to IDLE.
  - Stop=0: pulse `ferr`; the byte is discarded.
  - Parity mismatch: pulse `perr`; the byte is discarded. If both errors occur, both pulse.
  - Good frame with FIFO not full: push the byte.
  - Good frame with FIFO full: drop the byte and set `overrun`.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - When full, the FIFO still accepts a push in the same cycle as a pop.
  - Pointers wrap modulo FIFO_DEPTH.
- `clr_ovr` and a new overrun in the same cycle: `overrun` stays 1, because set wins.

## Timing
- Reset values of outputs:
  - `rdata`=0x00, `rvalid`=0, `fifo_cnt`=0.
  - `ferr`=0, `perr`=0, `overrun`=0.
- Internal state at reset: FSM in IDLE, all counters 0, `rx_s`=1.
- Reset asserted mid-frame aborts the frame and empties the FIFO immediately, because the reset is asynchronous.
- Latency:
  - `rx` edge to `rx_s`: 2 cycles.
  - Stop sample to `rvalid`/`fifo_cnt` update: 1 cycle.
  - Stop sample to `ferr`/`perr` pulse: 1 cycle.
- `rdata` is the registered head entry and changes only on pop, or on a push into an empty FIFO.
- Frame length: 10 bit-times for 8N1, 11 with parity. One bit-time is 16·CLK_DIV clocks.
- Back-to-back frames are supported: a start edge is recognised on the first cycle after entering IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1, the PARITY state exists, and `perr` is live.
- Undefined: the frame is 8N1, PARITY is removed, and `perr` is driven constant 0. The port list is unchanged.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - the constants `OS_RATE`=16 and `OS_MID`=7;
  - the data width 8.
- Sub-module `uart_rx_buf` is the synchronous FIFO: push/pop, `rdata`, count, full/empty. It is reusable by the TX side.

## Test plan
All scenarios use CLK_DIV=27 at 50 MHz, i.e. 432 clocks per bit.
- **Reset with `rx` low:** RESETn low 100 ns while `rx`=0, then release and hold `rx`=0 for 6000 ns -> no frame, `rvalid`=0, `ferr`=0 throughout.
- **Single good frame:** send 0xA5 (8N1), `rready`=0 -> `rvalid`=1 and `rdata`=0xA5 one cycle after the stop sample; `fifo_cnt`=1.
- **Framing error:** send 0x3C with stop bit forced low -> one-cycle `ferr`, `fifo_cnt` stays 0, next frame 0x11 is received correctly.
- **Overrun:**
  - Send 0x01..0x05 back-to-back with `rready`=0 -> FIFO holds 0x01..0x04, `overrun`=1.
  - Then pop 4 bytes -> values in order 0x01..0x04.
  - Then pulse `clr_ovr` -> `overrun`=0.
- **False start:** a 100-clock low glitch on `rx` -> FSM returns to IDLE, no byte, no error.
- **Parity (macro defined):** send 0x07 with odd parity bit -> `perr` pulse, byte dropped. Resend with correct parity -> byte accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, oversampling points, byte width.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_W  = 8;
  localparam int OS_RATE = 16;
  localparam int OS_MID  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// Synchronous FIFO with a registered head byte; simultaneous push and pop are both honoured,
// including a push into a full FIFO that is being popped in the same cycle.
module uart_rx_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Head register follows the entry behind the popped one, or the incoming byte when that is the new head.
      if (do_pop) begin
        if (count > CW'(1))  rdata <= mem[rd_nxt];
        else if (do_push)    rdata <= wdata;
      end else if (do_push && empty) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a small RX FIFO.
// Without UART_RX_PARITY_EN the PARITY state is absent and perr is tied low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          rx,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ferr,
  output logic                          perr,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int         TW        = $clog2(CLK_DIV);
  localparam logic [3:0] OS_MID_C  = OS_MID[3:0];
  localparam logic [3:0] OS_LAST_C = 4'(OS_RATE - 1);

  rx_state_t         state, state_nxt;
  logic              rx_meta, rx_s, rx_prev;
  logic [1:0]        sync_ok;
  logic              start_edge;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [3:0]        os_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              os_clr, bit_clr, tick_clr, shift_en, stop_smp;
  logic              par_bad;
  logic              frame_ok, full, empty;

  // Input synchronizer; rx_prev only records samples taken after the flops hold real rx data,
  // so a line held low from reset never produces a start edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      sync_ok <= '0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      sync_ok <= {sync_ok[0], 1'b1};
      rx_prev <= rx_s & sync_ok[1];
    end
  end

  assign start_edge = rx_prev & ~rx_s;
  assign tick       = (tick_cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)             tick_cnt <= '0;
    else if (tick_clr || tick) tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

`ifdef UART_RX_PARITY_EN
  logic par_smp;
`endif

  always_comb begin
    state_nxt = state;
    os_clr    = 1'b0;
    bit_clr   = 1'b0;
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp   = 1'b0;
`endif
    case (state)
      IDLE: if (start_edge) begin
        state_nxt = START;
        os_clr    = 1'b1;
        tick_clr  = 1'b1;
      end
      START: if (tick && os_cnt == OS_MID_C) begin
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
          os_clr    = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      DATA: if (tick && os_cnt == OS_LAST_C) begin
        shift_en = 1'b1;
        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick && os_cnt == OS_LAST_C) begin
        par_smp   = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP: if (tick && os_cnt == OS_LAST_C) begin
        stop_smp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      os_cnt  <= '0;
      bit_idx <= '0;
    end else begin
      if (os_clr)    os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 4'd1;
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
    end
  end

  // LSB arrives first: each new bit enters at the MSB and the byte shifts right.
  always_ff @(posedge CLK) begin
    if (shift_en) shreg <= {rx_s, shreg[DATA_W-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)      par_bad <= 1'b0;
    else if (par_smp) par_bad <= rx_s ^ even_par(shreg);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) perr <= 1'b0;
    else         perr <= stop_smp & par_bad;
  end
`else
  assign par_bad = 1'b0;
  assign perr    = 1'b0;
`endif

  assign frame_ok = stop_smp & rx_s & ~par_bad;

  // Overrun set has priority over the clear request.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ferr <= stop_smp & ~rx_s;
      if (frame_ok && full && !(rready && rvalid)) overrun <= 1'b1;
      else if (clr_ovr)                              overrun <= 1'b0;
    end
  end

  uart_rx_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_buf (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (frame_ok),
    .wdata (shreg),
    .pop   (rready),
    .rdata (rdata),
    .count (fifo_cnt),
    .full  (full),
    .empty (empty)
  );

  assign rvalid = ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLK_DIV=27 (432 clocks per bit), 50 MHz clock.
// Frames carry an even-parity bit automatically when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

  localparam int CLK_DIV    = 27;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Start-bit launch to rvalid rise: 3 sync/edge cycles + 152 ticks of 27 clocks (+16 ticks with parity).
  localparam int EXP_RISE = 4107 + PAR_BITS * BIT_CLKS;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       rx = 1'b1;
  logic       rready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] fifo_cnt;
  logic       ferr, perr, overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic rvalid_d = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .rx(rx), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .fifo_cnt(fifo_cnt), .ferr(ferr), .perr(perr),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (perr) perr_cnt <= perr_cnt + 1;
    rvalid_d <= rvalid;
    if (rvalid && !rvalid_d) rise_cyc <= cyc;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT_CLKS) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (BIT_CLKS) @(negedge CLK);
`endif
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge CLK);
    rx = 1'b1;
  endtask

  task automatic pop_byte();
    rready = 1'b1;
    @(negedge CLK);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    RESETn = 1'b0;
    rx = 1'b0;
    #50;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %0h expected 00", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b expected 0", rvalid); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", ferr); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", perr); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    #50;
    @(negedge CLK);
    RESETn = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge CLK);
      if (rvalid !== 1'b0 || ferr !== 1'b0 || fifo_cnt !== 3'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rx_low_from_reset: got %0d bad cycles expected 0", bad); end
    rx = 1'b1;
    repeat (50) @(negedge CLK);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge CLK);
    checks++;
    if ((rise_cyc - start_cyc) < EXP_RISE - 4 || (rise_cyc - start_cyc) > EXP_RISE + 4) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", rise_cyc - start_cyc, EXP_RISE);
    end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %0b expected 1", rvalid); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL single_rdata: got %0h expected a5", rdata); end
    checks++; if (fifo_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", fifo_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr: got %0d pulses expected 0", ferr_cnt); end
    pop_byte();
    checks++; if (rvalid !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL single_pop: got rvalid=%0b cnt=%0d expected 0/0", rvalid, fifo_cnt);
    end
  endtask

  task automatic test_framing();
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge CLK);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
    checks++; if (fifo_cnt !== 3'd0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL ferr_discard: got cnt=%0d rvalid=%0b expected 0/0", fifo_cnt, rvalid);
    end
    send_frame(8'h11, 1'b1);
    repeat (2) @(negedge CLK);
    checks++; if (rdata !== 8'h11 || fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL after_ferr_frame: got %0h cnt=%0d expected 11 cnt=1", rdata, fifo_cnt);
    end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL after_ferr_no_ferr: got %0d expected 1", ferr_cnt - f0); end
    pop_byte();
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      if (v == 4) begin
        checks++; if (fifo_cnt !== 3'd4 || overrun !== 1'b0) begin
          errors++; $display("FAIL fill4: got cnt=%0d ovr=%0b expected 4/0", fifo_cnt, overrun);
        end
      end
    end
    @(negedge CLK);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b expected 1", overrun); end
    checks++; if (fifo_cnt !== 3'd4) begin errors++; $display("FAIL overrun_cnt: got %0d expected 4", fifo_cnt); end
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      checks++; if (rdata !== exp_b) begin errors++; $display("FAIL pop_order: got %0h expected %0h", rdata, exp_b); end
      pop_byte();
    end
    checks++; if (rvalid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL drained: got rvalid=%0b ovr=%0b expected 0/1", rvalid, overrun);
    end
    clr_ovr = 1'b1;
    @(negedge CLK);
    clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_ovr: got %0b expected 0", overrun); end
  endtask

  task automatic test_false_start();
    int f0;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (100) @(negedge CLK);
    rx = 1'b1;
    repeat (1000) @(negedge CLK);
    checks++; if (rvalid !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL glitch_no_byte: got rvalid=%0b cnt=%0d expected 0/0", rvalid, fifo_cnt);
    end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_no_ferr: got %0d expected 0", ferr_cnt - f0); end
    send_frame(8'h5A, 1'b1);
    repeat (2) @(negedge CLK);
    checks++; if (rdata !== 8'h5A || fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL after_glitch: got %0h cnt=%0d expected 5a cnt=1", rdata, fifo_cnt);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    p0 = perr_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (20) @(negedge CLK);
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL perr_pulse: got %0d expected 1", perr_cnt - p0); end
    checks++; if (fifo_cnt !== 3'd1) begin errors++; $display("FAIL perr_drop: got %0d expected 1", fifo_cnt); end
    send_frame(8'h07, 1'b1);
    repeat (2) @(negedge CLK);
    checks++; if (fifo_cnt !== 3'd2) begin errors++; $display("FAIL par_good_cnt: got %0d expected 2", fifo_cnt); end
    pop_byte();
    checks++; if (rdata !== 8'h07) begin errors++; $display("FAIL par_good_data: got %0h expected 07", rdata); end
  endtask
`else
  task automatic test_parity();
    checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL perr_tied: got %0d pulses expected 0", perr_cnt); end
  endtask
`endif

  task automatic test_reset_midframe();
    rx = 1'b0;
    repeat (1000) @(negedge CLK);
    #3 RESETn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL async_reset_flush: got rvalid=%0b cnt=%0d expected 0/0", rvalid, fifo_cnt);
    end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL async_reset_rdata: got %0h expected 00", rdata); end
    rx = 1'b1;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (500) @(negedge CLK);
    checks++; if (rvalid !== 1'b0 || ferr_cnt !== 1) begin
      errors++; $display("FAIL post_reset_idle: got rvalid=%0b ferr_cnt=%0d expected 0/1", rvalid, ferr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_framing();
    test_overrun();
    test_false_start();
    test_parity();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
